// File: rtl/armleocpu_mem_responder.sv
// Burst memory responder: word-addressed storage behind an Avalon-style burst port.
// Reads stream N beats back-to-back; writes accept N beats with optional idle gaps.
module armleocpu_mem_responder #(
  parameter int DEPTH_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [33:0] m_address,
  input  logic [3:0]  m_burstcount,
  output logic        m_waitrequest,
  input  logic        m_read,
  output logic [31:0] m_readdata,
  output logic        m_readdatavalid,
  input  logic        m_write,
  input  logic [31:0] m_writedata,
  input  logic [3:0]  m_byteenable
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam int unsigned WORDS = 32'd1 << DEPTH_W;

  logic [1:0]         r_state;
  logic [33:0]        r_addr;
  logic [4:0]         r_remaining;
  logic [31:0]        r_mem [WORDS];

  logic [33:0]        w_beat_addr;
  logic [DEPTH_W-1:0] w_idx;
  logic               w_in_range;
  logic [31:0]        w_rd_data;
  logic [4:0]         w_beats;
  logic               w_wr_en;

  // Address of the beat handled this cycle: the command address in IDLE, the running pointer otherwise.
  always_comb begin
    w_beat_addr = m_address;
    if (r_state == ST_IDLE) begin
      w_beat_addr = m_address;
    end else begin
      w_beat_addr = r_addr;
    end
  end

  assign w_idx      = w_beat_addr[DEPTH_W+1:2];
  assign w_in_range = ~|w_beat_addr[33:DEPTH_W+2];
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : 32'd0;
  assign w_beats    = (m_burstcount == 4'd0) ? 5'd16 : {1'b0, m_burstcount};

  // Storage write strobe; a read in IDLE wins over a simultaneous write.
  always_comb begin
    w_wr_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!m_waitrequest && m_write && !m_read) begin
          w_wr_en = 1'b1;
        end else begin
          w_wr_en = 1'b0;
        end
      end
      ST_WRITE: w_wr_en = m_write;
      default:  w_wr_en = 1'b0;
    endcase
  end

  // Storage array; intentionally not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_en && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (m_byteenable[b]) begin
          r_mem[w_idx][8*b +: 8] <= m_writedata[8*b +: 8];
        end
      end
    end
  end

  // Burst control FSM; waitrequest comes up high out of reset and drops on the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_addr          <= 34'd0;
      r_remaining     <= 5'd0;
      m_waitrequest   <= 1'b1;
      m_readdatavalid <= 1'b0;
      m_readdata      <= 32'd0;
    end else begin
      m_readdatavalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m_waitrequest) begin
            m_waitrequest <= 1'b0;
          end else if (m_read) begin
            r_state         <= ST_READ;
            m_waitrequest   <= 1'b1;
            m_readdatavalid <= 1'b1;
            m_readdata      <= w_rd_data;
            r_addr          <= m_address + 34'd4;
            r_remaining     <= w_beats - 5'd1;
          end else if (m_write) begin
            r_addr      <= m_address + 34'd4;
            r_remaining <= w_beats - 5'd1;
            if (w_beats != 5'd1) begin
              r_state <= ST_WRITE;
            end
          end
        end
        ST_READ: begin
          if (r_remaining != 5'd0) begin
            m_readdatavalid <= 1'b1;
            m_readdata      <= w_rd_data;
            r_addr          <= r_addr + 34'd4;
            r_remaining     <= r_remaining - 5'd1;
          end else begin
            r_state       <= ST_IDLE;
            m_waitrequest <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (m_write) begin
            r_addr      <= r_addr + 34'd4;
            r_remaining <= r_remaining - 5'd1;
            if (r_remaining == 5'd1) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          m_waitrequest <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_mem_responder.sv
// Self-checking bench for armleocpu_mem_responder: directed cases plus random bursts
// compared against a word-level memory model.
module tb_armleocpu_mem_responder;

  localparam int DW = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [33:0] m_address = 34'd0;
  logic [3:0]  m_burstcount = 4'd0;
  logic        m_waitrequest;
  logic        m_read = 1'b0;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        m_write = 1'b0;
  logic [31:0] m_writedata = 32'd0;
  logic [3:0]  m_byteenable = 4'd0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl_mem [int];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_be [16];

  armleocpu_mem_responder #(.DEPTH_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .m_address(m_address), .m_burstcount(m_burstcount),
    .m_waitrequest(m_waitrequest), .m_read(m_read), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mdl_in_range(input logic [33:0] a);
    return (a >> (DW + 2)) == 34'd0;
  endfunction

  task automatic mdl_read(input logic [33:0] a, output logic [31:0] v, output bit known);
    int idx;
    v = 32'd0;
    known = 1'b1;
    if (mdl_in_range(a)) begin
      idx = int'(a >> 2);
      if (mdl_mem.exists(idx)) v = mdl_mem[idx];
      else known = 1'b0;
    end
  endtask

  task automatic mdl_write(input logic [33:0] a, input logic [31:0] d, input logic [3:0] be);
    int idx;
    logic [31:0] w;
    if (mdl_in_range(a)) begin
      idx = int'(a >> 2);
      if (mdl_mem.exists(idx)) begin
        w = mdl_mem[idx];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl_mem[idx] = w;
      end else if (be == 4'hF) begin
        mdl_mem[idx] = d;
      end
    end
  endtask

  // Write burst of n beats from wr_data/wr_be; gaps[k] inserts an idle cycle before beat k.
  task automatic do_write(input logic [33:0] addr, input int n, input logic [15:0] gaps);
    logic [33:0] a;
    a = addr;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k > 0 && gaps[k]) begin
        m_write = 1'b0;
        m_read = 1'b0;
        @(negedge clk);
      end
      check("wr_wait", {31'd0, m_waitrequest}, 32'd0);
      m_write      = 1'b1;
      m_writedata  = wr_data[k];
      m_byteenable = wr_be[k];
      if (k == 0) begin
        m_address    = addr;
        m_burstcount = 4'(n);
        m_read       = 1'b0;
      end else begin
        m_address    = {2'($urandom), $urandom};
        m_burstcount = 4'($urandom);
        m_read       = 1'($urandom);
      end
      mdl_write(a, wr_data[k], wr_be[k]);
      a = a + 34'd4;
    end
    @(negedge clk);
    m_write = 1'b0;
    m_read  = 1'b0;
  endtask

  // Read burst of n beats; with also_write a write is presented alongside the command.
  task automatic do_read(input logic [33:0] addr, input int n, input bit also_write);
    logic [31:0] exp_v [16];
    bit          exp_k [16];
    @(negedge clk);
    check("rd_cmd_wait", {31'd0, m_waitrequest}, 32'd0);
    m_read       = 1'b1;
    m_address    = addr;
    m_burstcount = 4'(n);
    if (also_write) begin
      m_write      = 1'b1;
      m_writedata  = $urandom;
      m_byteenable = 4'hF;
    end
    for (int k = 0; k < n; k++) mdl_read(addr + 34'(4 * k), exp_v[k], exp_k[k]);
    @(negedge clk);
    m_read    = 1'b0;
    m_write   = 1'b0;
    m_address = {2'($urandom), $urandom};
    for (int k = 0; k < n; k++) begin
      check("rd_valid", {31'd0, m_readdatavalid}, 32'd1);
      check("rd_busy", {31'd0, m_waitrequest}, 32'd1);
      if (exp_k[k]) check("rd_data", m_readdata, exp_v[k]);
      @(negedge clk);
    end
    check("rd_end_valid", {31'd0, m_readdatavalid}, 32'd0);
    check("rd_end_wait", {31'd0, m_waitrequest}, 32'd0);
    if (exp_k[n-1]) check("rd_hold", m_readdata, exp_v[n-1]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] addr;
    int          n;
    logic [15:0] gaps;

    // Reset values
    #3 rst_n = 1'b0;
    #2;
    check("rst_wait", {31'd0, m_waitrequest}, 32'd1);
    check("rst_valid", {31'd0, m_readdatavalid}, 32'd0);
    check("rst_data", m_readdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold_wait", {31'd0, m_waitrequest}, 32'd1);

    // Release with a read pending: first clock only drops waitrequest
    @(negedge clk);
    rst_n = 1'b1;
    m_read = 1'b1;
    m_address = 34'd0;
    m_burstcount = 4'd1;
    #1 check("rel_wait_pre", {31'd0, m_waitrequest}, 32'd1);
    @(negedge clk);
    check("rel_wait_post", {31'd0, m_waitrequest}, 32'd0);
    check("rel_no_accept", {31'd0, m_readdatavalid}, 32'd0);
    m_read = 1'b0;

    // Fill words 0..127 and the four words below the top of storage
    for (int blk = 0; blk < 8; blk++) begin
      for (int k = 0; k < 16; k++) begin
        wr_data[k] = $urandom;
        wr_be[k] = 4'hF;
      end
      do_write(34'(blk * 64), 16, 16'd0);
    end
    for (int k = 0; k < 4; k++) begin
      wr_data[k] = $urandom;
      wr_be[k] = 4'hF;
    end
    do_write(34'h3FF0, 4, 16'd0);

    // Four-beat write then read at 0x100
    for (int k = 0; k < 4; k++) begin
      wr_data[k] = 32'(32'h11111111 * (k + 1));
      wr_be[k] = 4'hF;
    end
    do_write(34'h100, 4, 16'd0);
    do_read(34'h100, 4, 1'b0);

    // Burstcount 0 means 16 beats
    do_read(34'h0, 16, 1'b0);

    // Partial byte-enable merge
    wr_data[0] = 32'hAABBCCDD;
    wr_be[0] = 4'hF;
    do_write(34'h200, 1, 16'd0);
    wr_data[0] = 32'h12345678;
    wr_be[0] = 4'b0101;
    do_write(34'h200, 1, 16'd0);
    do_read(34'h200, 1, 1'b0);

    // Out-of-range reads return zero, writes there leave aliased word 0 alone
    do_read(34'h4000, 2, 1'b0);
    wr_data[0] = 32'hDEADBEEF;
    wr_be[0] = 4'hF;
    do_write(34'h4000, 1, 16'd0);
    do_read(34'h0, 1, 1'b0);

    // Burst straddling the top of storage
    do_read(34'h3FF0, 8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      wr_data[k] = $urandom;
      wr_be[k] = 4'hF;
    end
    do_write(34'h3FF0, 8, 16'd0);
    do_read(34'h0, 4, 1'b0);
    do_read(34'h3FF0, 4, 1'b0);

    // Write with an idle gap before beat 2, then immediate read; then read+write together
    for (int k = 0; k < 3; k++) begin
      wr_data[k] = $urandom;
      wr_be[k] = 4'hF;
    end
    do_write(34'h300, 3, 16'b100);
    do_read(34'h300, 3, 1'b0);
    do_read(34'h300, 1, 1'b1);
    do_read(34'h300, 3, 1'b0);

    // Reset pulse after two beats of a four-beat read
    @(negedge clk);
    m_read = 1'b1;
    m_address = 34'h100;
    m_burstcount = 4'd4;
    @(negedge clk);
    m_read = 1'b0;
    check("mid_b0", m_readdata, 32'h11111111);
    @(negedge clk);
    check("mid_b1", m_readdata, 32'h22222222);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, m_readdatavalid}, 32'd0);
    check("mid_rst_wait", {31'd0, m_waitrequest}, 32'd1);
    check("mid_rst_data", m_readdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rel_wait", {31'd0, m_waitrequest}, 32'd1);
    @(negedge clk);
    check("mid_post_wait", {31'd0, m_waitrequest}, 32'd0);
    check("mid_post_valid", {31'd0, m_readdatavalid}, 32'd0);
    @(negedge clk);
    check("mid_no_beats", {31'd0, m_readdatavalid}, 32'd0);
    do_read(34'h100, 4, 1'b0);

    // Random bursts against the model
    for (int op = 0; op < 40; op++) begin
      n = $urandom_range(1, 16);
      addr = 34'($urandom_range(0, 128 - n) * 4) | 34'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) addr[33:30] = 4'($urandom_range(1, 14));
      if ($urandom_range(0, 1) == 1) begin
        do_read(addr, n, 1'($urandom));
      end else begin
        for (int k = 0; k < 16; k++) begin
          wr_data[k] = $urandom;
          wr_be[k] = 4'($urandom_range(0, 15));
        end
        gaps = 16'($urandom);
        do_write(addr, n, gaps);
      end
    end
    for (int blk = 0; blk < 8; blk++) do_read(34'(blk * 64), 16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
